// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the overflow timer: mode encodings, default
// parameter values and the prescaler register width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package timer_pkg;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_PRESCALE = 10;

   // A prescaler of 1 still needs a 1-bit register so the compare is legal.
   function automatic int ps_width(input int prescale);
      return (prescale <= 1) ? 1 : $clog2(prescale);
   endfunction

endpackage : timer_pkg

// File: rtl/overflow_timer_prescaler.sv
// -----------------------------------------------------------------------------
// prescaler
// Divides the clock by PRESCALE, producing a one-cycle tick strobe.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset
//   clr_ps_i  restart the division from zero (driven by timer LOAD)
//   en_i      count enable (already qualified with RUNNING by the parent)
//   tick_o    high in the enabled cycle where the prescaler sits at PRESCALE-1
// -----------------------------------------------------------------------------
module prescaler
   import timer_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_ps_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int PS_WIDTH = ps_width(PRESCALE);
   localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

   logic [PS_WIDTH-1:0] ps_q;
   logic [PS_WIDTH-1:0] ps_d;
   logic                at_last_s;

   assign at_last_s = (ps_q == PS_LAST);
   assign tick_o    = at_last_s & en_i;

   // Next prescaler value: clear wins over counting; wrap at the last step.
   always_comb begin
      ps_d = ps_q;
      if (clr_ps_i) begin
         ps_d = '0;
      end else if (en_i) begin
         if (at_last_s) begin
            ps_d = '0;
         end else begin
            ps_d = ps_q + PS_WIDTH'(1);
         end
      end else begin
         ps_d = ps_q;
      end
   end

   // Prescaler state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end

endmodule : prescaler

// File: rtl/overflow_timer.sv
// -----------------------------------------------------------------------------
// overflow_timer
// Programmable interval timer. A fixed prescaler generates ticks; each tick
// decrements a loadable down-counter. At terminal count a sticky overflow flag
// is raised and held until acknowledged. Periodic mode reloads the interval,
// one-shot mode stops the timer.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   en_i        count enable; low freezes prescaler and counter
//   load_i      one-cycle strobe arming the timer with load_val_i / mode_i
//   load_val_i  interval value (also captured as the reload value)
//   mode_i      0 periodic, 1 one-shot; sampled on load_i
//   ack_i       clears overflow_o and missed_o
//   overflow_o  sticky terminal-count flag
//   missed_o    sticky flag: terminal count while overflow_o already set
//   tick_o      prescaler strobe
//   count_o     current down-count
//   running_o   timer armed
// -----------------------------------------------------------------------------
module overflow_timer
   import timer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             mode_i,
   input  logic             ack_i,
   output logic             overflow_o,
   output logic             missed_o,
   output logic             tick_o,
   output logic [WIDTH-1:0] count_o,
   output logic             running_o
);

   logic [WIDTH-1:0] count_q,    count_d;
   logic [WIDTH-1:0] reload_q,   reload_d;
   logic             mode_q,     mode_d;
   logic             running_q,  running_d;
   logic             overflow_q, overflow_d;
   logic             missed_q,   missed_d;
   logic             tick_s;
   logic             terminal_s;

   prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_ps_i (load_i),
      .en_i     (en_i & running_q),
      .tick_o   (tick_s)
   );

   // A tick coinciding with LOAD is discarded, so it can never be terminal.
   assign terminal_s = tick_s & ~load_i & (count_q == '0);

   // Next-state for counter, reload value, mode, run state and flags.
   always_comb begin
      count_d    = count_q;
      reload_d   = reload_q;
      mode_d     = mode_q;
      running_d  = running_q;
      overflow_d = overflow_q;
      missed_d   = missed_q;

      if (load_i) begin
         count_d   = load_val_i;
         reload_d  = load_val_i;
         mode_d    = mode_i;
         running_d = 1'b1;
      end else if (tick_s) begin
         if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
         end else if (mode_q == MODE_PERIODIC) begin
            count_d = reload_q;
         end else begin
            count_d   = '0;
            running_d = 1'b0;
         end
      end else begin
         count_d = count_q;
      end

      // New terminal event beats a coincident ACK; MISSED only sets when
      // the previous event was still pending and not being acknowledged.
      if (terminal_s) begin
         overflow_d = 1'b1;
         if (overflow_q & ~ack_i) begin
            missed_d = 1'b1;
         end else begin
            missed_d = missed_q;
         end
      end else if (ack_i) begin
         overflow_d = 1'b0;
         missed_d   = 1'b0;
      end else begin
         overflow_d = overflow_q;
         missed_d   = missed_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q    <= '0;
         reload_q   <= '0;
         mode_q     <= MODE_PERIODIC;
         running_q  <= 1'b0;
         overflow_q <= 1'b0;
         missed_q   <= 1'b0;
      end else begin
         count_q    <= count_d;
         reload_q   <= reload_d;
         mode_q     <= mode_d;
         running_q  <= running_d;
         overflow_q <= overflow_d;
         missed_q   <= missed_d;
      end
   end

   assign overflow_o = overflow_q;
   assign missed_o   = missed_q;
   assign tick_o     = tick_s;
   assign count_o    = count_q;
   assign running_o  = running_q;

endmodule : overflow_timer
